// File: rtl/swd_xfer_engine.sv
// SWD transaction engine: serialises one host request into a complete SWD packet
// (header, turnarounds, ACK, data, parity, idle tail), retrying on WAIT, or emits a line reset.
module swd_xfer_engine #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TURN_W    = 1,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned MAX_RETRY = 4,
  parameter int unsigned IDLE_BITS = 2,
  parameter int unsigned LRST_HI   = 56
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_lrst,
  input  logic              req_apndp,
  input  logic              req_rnw,
  input  logic [1:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [2:0]        rsp_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic [3:0]        rsp_retries,
  output logic              swclk,
  output logic              swdio_o,
  output logic              swdio_oe,
  input  logic              swdio_i
);
  localparam int unsigned MaxA    = (LRST_HI > DATA_W + 1) ? LRST_HI : DATA_W + 1;
  localparam int unsigned MaxBits = (MaxA > IDLE_BITS) ? MaxA : IDLE_BITS;
  localparam int unsigned CntW    = $clog2(MaxBits + 1);
  localparam int unsigned DivW    = $clog2(2 * CLK_DIV);
  localparam int unsigned IdxW    = $clog2(DATA_W);
  localparam logic [2:0]  AckOk   = 3'b001;
  localparam logic [2:0]  AckWait = 3'b010;

  typedef enum logic [3:0] {
    StIdle, StLrstHi, StLrstLo, StHdr, StTrn1, StAck, StTrn2,
    StWdata, StRdata, StTrn3, StTail, StDone
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_init;
  logic [DivW-1:0]     r_div;
  logic [CntW-1:0]     r_bit;
  logic                r_lrst;
  logic                r_apndp;
  logic                r_rnw;
  logic [1:0]          r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_rpar;
  logic [2:0]          r_ack;
  logic [3:0]          r_retry;
  logic [2:0]          r_rsp_ack;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_perr;
  logic [3:0]          r_rsp_retries;

  logic                w_busy;
  logic                w_accept;
  logic                w_bit_end;
  logic                w_sample;
  logic                w_last;
  logic                w_ok_rd;
  logic [CntW-1:0]     w_len;
  logic [7:0]          w_hdr;

  assign w_busy    = (r_state != StIdle) && (r_state != StDone);
  assign w_accept  = req_valid && req_ready;
  assign w_bit_end = w_busy && (r_div == DivW'(2 * CLK_DIV - 1));
  assign w_sample  = w_busy && (r_div == DivW'(CLK_DIV - 1));
  assign w_last    = w_bit_end && (r_bit == w_len - CntW'(1));
  assign w_ok_rd   = !r_lrst && (r_ack == AckOk) && r_rnw;
  // LSB goes out first: start, APnDP, RnW, A2, A3, parity, stop, park
  assign w_hdr     = {1'b1, 1'b0, ^{r_apndp, r_rnw, r_addr}, r_addr[1], r_addr[0],
                      r_rnw, r_apndp, 1'b1};

  assign req_ready   = (r_state == StIdle) && !r_init;
  assign rsp_valid   = (r_state == StDone);
  assign swclk       = w_busy && (r_div >= DivW'(CLK_DIV));
  assign rsp_ack     = r_rsp_ack;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_perr    = r_rsp_perr;
  assign rsp_retries = r_rsp_retries;

  always_comb begin
    w_len = CntW'(1);
    unique case (r_state)
      StLrstHi:                 w_len = CntW'(LRST_HI);
      StLrstLo, StTail:         w_len = CntW'(IDLE_BITS);
      StHdr:                    w_len = CntW'(8);
      StTrn1, StTrn2, StTrn3:   w_len = CntW'(TURN_W);
      StAck:                    w_len = CntW'(3);
      StWdata, StRdata:         w_len = CntW'(DATA_W + 1);
      default:                  w_len = CntW'(1);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_nxt = req_lrst ? StLrstHi : StHdr;
      StLrstHi: if (w_last) w_state_nxt = StLrstLo;
      StLrstLo: if (w_last) w_state_nxt = StDone;
      StHdr:    if (w_last) w_state_nxt = StTrn1;
      StTrn1:   if (w_last) w_state_nxt = StAck;
      StAck:    if (w_last) w_state_nxt = ((r_ack == AckOk) && r_rnw) ? StRdata : StTrn2;
      StTrn2:   if (w_last) w_state_nxt = (r_ack == AckOk) ? StWdata : StTail;
      StWdata:  if (w_last) w_state_nxt = StTail;
      StRdata:  if (w_last) w_state_nxt = StTrn3;
      StTrn3:   if (w_last) w_state_nxt = StTail;
      StTail: begin
        if (w_last) begin
          w_state_nxt = ((r_ack == AckWait) && (r_retry < 4'(MAX_RETRY))) ? StHdr : StDone;
        end
      end
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    swdio_oe = 1'b0;
    swdio_o  = 1'b0;
    unique case (r_state)
      StIdle:                   swdio_oe = !r_init;
      StLrstHi: begin
        swdio_oe = 1'b1;
        swdio_o  = 1'b1;
      end
      StLrstLo, StTail, StDone: swdio_oe = 1'b1;
      StHdr: begin
        swdio_oe = 1'b1;
        swdio_o  = w_hdr[r_bit[2:0]];
      end
      StWdata: begin
        swdio_oe = 1'b1;
        swdio_o  = (r_bit < CntW'(DATA_W)) ? r_data[r_bit[IdxW-1:0]] : ^r_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      r_state       <= StIdle;
      r_init        <= 1'b1;
      r_div         <= '0;
      r_bit         <= '0;
      r_lrst        <= 1'b0;
      r_apndp       <= 1'b0;
      r_rnw         <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_rpar        <= 1'b0;
      r_ack         <= '0;
      r_retry       <= '0;
      r_rsp_ack     <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_perr    <= 1'b0;
      r_rsp_retries <= '0;
    end else begin
      r_init  <= 1'b0;
      r_state <= w_state_nxt;
      r_div   <= (!w_busy || w_bit_end) ? '0 : r_div + DivW'(1);
      if (!w_busy || w_last) begin
        r_bit <= '0;
      end else if (w_bit_end) begin
        r_bit <= r_bit + CntW'(1);
      end
      if (w_accept) begin
        r_lrst  <= req_lrst;
        r_apndp <= req_apndp;
        r_rnw   <= req_rnw;
        r_addr  <= req_addr;
        r_data  <= req_wdata;
        r_retry <= '0;
      end
      if (w_sample && (r_state == StAck)) begin
        r_ack[r_bit[1:0]] <= swdio_i;
      end
      if (w_sample && (r_state == StRdata)) begin
        if (r_bit < CntW'(DATA_W)) begin
          r_data[r_bit[IdxW-1:0]] <= swdio_i;
        end else begin
          r_rpar <= swdio_i;
        end
      end
      if ((r_state == StTail) && (w_state_nxt == StHdr)) begin
        r_retry <= r_retry + 4'd1;
      end
      // Response fields are captured on entry to DONE and held until the next one
      if ((w_state_nxt == StDone) && (r_state != StDone)) begin
        r_rsp_ack     <= r_lrst ? 3'b000 : r_ack;
        r_rsp_rdata   <= w_ok_rd ? r_data : '0;
        r_rsp_perr    <= w_ok_rd && (r_rpar != ^r_data);
        r_rsp_retries <= r_lrst ? 4'd0 : r_retry;
      end
    end
  end

endmodule

// File: tb/tb_swd_xfer_engine.sv
// Bench for swd_xfer_engine: two parameterisations, a wire-level SWD target model and
// expected bit streams built from the packet rules.
module tb_swd_xfer_engine;
  localparam int unsigned DwA = 32, TwA = 1, CdA = 2, MrA = 4, IbA = 2, LhA = 56;
  localparam int unsigned DwB = 8,  TwB = 3, CdB = 1, MrB = 2, IbB = 3, LhB = 50;

  logic        sck = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_lrst = 1'b0;
  logic        req_apndp = 1'b0;
  logic        req_rnw = 1'b0;
  logic [1:0]  req_addr = 2'b00;
  logic [31:0] req_wdata = 32'h0;
  logic        swdio_i = 1'b0;

  logic        a_valid_in, a_ready, a_rsp_valid, a_perr, a_swclk, a_o, a_oe;
  logic [2:0]  a_ack;
  logic [31:0] a_rdata;
  logic [3:0]  a_ret;
  logic        b_valid_in, b_ready, b_rsp_valid, b_perr, b_swclk, b_o, b_oe;
  logic [2:0]  b_ack;
  logic [7:0]  b_rdata;
  logic [3:0]  b_ret;

  logic        cur_ready, cur_rsp_valid, cur_perr, cur_swclk, cur_o, cur_oe;
  logic [2:0]  cur_ack;
  logic [31:0] cur_rdata;
  logic [3:0]  cur_ret;

  int n_checks = 0;
  int n_pass   = 0;

  bit          exp_oe[$];
  bit          exp_o[$];
  bit          drv[$];
  bit          cap_o[$];
  logic [2:0]  e_ack;
  logic [31:0] e_rdata;
  logic        e_perr;
  logic [3:0]  e_ret;

  always #5 sck = ~sck;

  assign a_valid_in    = req_valid && !sel;
  assign b_valid_in    = req_valid && sel;
  assign cur_ready     = sel ? b_ready : a_ready;
  assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign cur_perr      = sel ? b_perr : a_perr;
  assign cur_swclk     = sel ? b_swclk : a_swclk;
  assign cur_o         = sel ? b_o : a_o;
  assign cur_oe        = sel ? b_oe : a_oe;
  assign cur_ack       = sel ? b_ack : a_ack;
  assign cur_rdata     = sel ? {24'h0, b_rdata} : a_rdata;
  assign cur_ret       = sel ? b_ret : a_ret;

  swd_xfer_engine #(
    .DATA_W(DwA), .TURN_W(TwA), .CLK_DIV(CdA), .MAX_RETRY(MrA), .IDLE_BITS(IbA), .LRST_HI(LhA)
  ) u_dut_a (
    .sck(sck), .rst(rst), .req_valid(a_valid_in), .req_ready(a_ready), .req_lrst(req_lrst),
    .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ack(a_ack), .rsp_rdata(a_rdata), .rsp_perr(a_perr),
    .rsp_retries(a_ret), .swclk(a_swclk), .swdio_o(a_o), .swdio_oe(a_oe), .swdio_i(swdio_i)
  );

  swd_xfer_engine #(
    .DATA_W(DwB), .TURN_W(TwB), .CLK_DIV(CdB), .MAX_RETRY(MrB), .IDLE_BITS(IbB), .LRST_HI(LhB)
  ) u_dut_b (
    .sck(sck), .rst(rst), .req_valid(b_valid_in), .req_ready(b_ready), .req_lrst(req_lrst),
    .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata[7:0]),
    .rsp_valid(b_rsp_valid), .rsp_ack(b_ack), .rsp_rdata(b_rdata), .rsp_perr(b_perr),
    .rsp_retries(b_ret), .swclk(b_swclk), .swdio_o(b_o), .swdio_oe(b_oe), .swdio_i(swdio_i)
  );

  function automatic int unsigned dw(); return sel ? DwB : DwA; endfunction
  function automatic int unsigned tw(); return sel ? TwB : TwA; endfunction
  function automatic int unsigned cd(); return sel ? CdB : CdA; endfunction
  function automatic int unsigned mr(); return sel ? MrB : MrA; endfunction
  function automatic int unsigned ib(); return sel ? IbB : IbA; endfunction
  function automatic int unsigned lh(); return sel ? LhB : LhA; endfunction
  function automatic bit rb(); return 1'($urandom_range(0, 1)); endfunction
  function automatic logic [31:0] dmask();
    return (dw() >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw()) - 32'h1);
  endfunction

  task automatic push_bit(input bit oe, input bit o, input bit d);
    exp_oe.push_back(oe);
    exp_o.push_back(o);
    drv.push_back(d);
  endtask

  // Expected wire stream (host oe/o per bit), target drive per bit, and final response.
  task automatic build(input bit lrst, input bit apndp, input bit rnw, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input bit flip,
                       input int n_wait, input logic [2:0] fin_ack);
    logic [31:0] wd, rd;
    logic [2:0]  a;
    bit          fin;
    int          att;
    exp_oe.delete(); exp_o.delete(); drv.delete();
    wd = wdata & dmask();
    rd = rdata & dmask();
    e_ack = 3'b000; e_rdata = 32'h0; e_perr = 1'b0; e_ret = 4'd0;
    if (lrst) begin
      for (int i = 0; i < int'(lh()); i++) push_bit(1'b1, 1'b1, rb());
      for (int i = 0; i < int'(ib()); i++) push_bit(1'b1, 1'b0, rb());
      return;
    end
    fin = 1'b0;
    att = 0;
    a = fin_ack;
    while (!fin) begin
      a = (att < n_wait) ? 3'b010 : fin_ack;
      push_bit(1'b1, 1'b1, rb());
      push_bit(1'b1, apndp, rb());
      push_bit(1'b1, rnw, rb());
      push_bit(1'b1, addr[0], rb());
      push_bit(1'b1, addr[1], rb());
      push_bit(1'b1, apndp ^ rnw ^ addr[0] ^ addr[1], rb());
      push_bit(1'b1, 1'b0, rb());
      push_bit(1'b1, 1'b1, rb());
      for (int i = 0; i < int'(tw()); i++) push_bit(1'b0, 1'b0, rb());
      for (int i = 0; i < 3; i++) push_bit(1'b0, 1'b0, a[i]);
      if (a == 3'b001 && rnw) begin
        for (int i = 0; i < int'(dw()); i++) push_bit(1'b0, 1'b0, rd[i]);
        push_bit(1'b0, 1'b0, (^rd) ^ flip);
        for (int i = 0; i < int'(tw()); i++) push_bit(1'b0, 1'b0, rb());
        for (int i = 0; i < int'(ib()); i++) push_bit(1'b1, 1'b0, rb());
        e_rdata = rd;
        e_perr  = flip;
        fin     = 1'b1;
      end else if (a == 3'b001) begin
        for (int i = 0; i < int'(tw()); i++) push_bit(1'b0, 1'b0, rb());
        for (int i = 0; i < int'(dw()); i++) push_bit(1'b1, wd[i], rb());
        push_bit(1'b1, ^wd, rb());
        for (int i = 0; i < int'(ib()); i++) push_bit(1'b1, 1'b0, rb());
        fin = 1'b1;
      end else begin
        for (int i = 0; i < int'(tw()); i++) push_bit(1'b0, 1'b0, rb());
        for (int i = 0; i < int'(ib()); i++) push_bit(1'b1, 1'b0, rb());
        if (a == 3'b010 && int'(e_ret) < int'(mr())) e_ret = e_ret + 4'd1;
        else fin = 1'b1;
      end
      att++;
    end
    e_ack = a;
  endtask

  task automatic run_xfer(input string name, input bit lrst, input bit apndp, input bit rnw,
                          input logic [1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input bit flip, input int n_wait,
                          input logic [2:0] fin_ack, input int poke_bit, input int abort_bit);
    int    mism;
    string msg;
    build(lrst, apndp, rnw, addr, wdata, rdata, flip, n_wait, fin_ack);
    cap_o.delete();
    @(negedge sck);
    for (int i = 0; i < 50 && cur_ready !== 1'b1; i++) @(negedge sck);
    n_checks++;
    if (cur_ready !== 1'b1) begin
      $display("FAIL %s ready: got %b want 1", name, cur_ready);
      return;
    end
    n_pass++;
    req_lrst = lrst; req_apndp = apndp; req_rnw = rnw; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge sck);
    #1;
    req_valid = 1'b0;
    mism = 0;
    msg = "";
    for (int k = 0; k < exp_oe.size(); k++) begin
      swdio_i = drv[k];
      if (k == abort_bit) begin
        n_checks++;
        if (mism != 0) $display("FAIL %s wire: %0d bad, first %s", name, mism, msg);
        else n_pass++;
        rst = 1'b1;
        @(posedge sck);
        #1;
        n_checks++;
        if ({cur_oe, cur_swclk, cur_ready, cur_rsp_valid, cur_ack, cur_rdata, cur_perr,
             cur_ret} !== 44'h0)
          $display("FAIL %s abort: got oe=%b clk=%b rdy=%b vld=%b ack=%b rd=%h pe=%b rt=%0d want all 0",
                   name, cur_oe, cur_swclk, cur_ready, cur_rsp_valid, cur_ack, cur_rdata,
                   cur_perr, cur_ret);
        else n_pass++;
        rst = 1'b0;
        @(posedge sck);
        #1;
        n_checks++;
        if ({cur_ready, cur_oe, cur_rsp_valid, cur_swclk} !== 4'b1100)
          $display("FAIL %s abort_idle: got rdy,oe,vld,clk=%b want 1100", name,
                   {cur_ready, cur_oe, cur_rsp_valid, cur_swclk});
        else n_pass++;
        mism = 0;
        for (int i = 0; i < int'(8 * cd()); i++) begin
          @(posedge sck);
          #1;
          if (cur_rsp_valid !== 1'b0 || cur_swclk !== 1'b0) mism++;
        end
        n_checks++;
        if (mism != 0) $display("FAIL %s abort_quiet: got %0d active cycles want 0", name, mism);
        else n_pass++;
        return;
      end
      if (k == poke_bit) begin
        req_lrst = 1'b0; req_rnw = 1'b1; req_valid = 1'b1;
      end
      if (cur_swclk !== 1'b0 || cur_oe !== exp_oe[k] || (exp_oe[k] && cur_o !== exp_o[k]) ||
          cur_rsp_valid !== 1'b0 || (k == poke_bit && cur_ready !== 1'b0)) begin
        if (mism == 0)
          msg = $sformatf("bit %0d lo: clk=%b oe=%b o=%b vld=%b rdy=%b want 0/%b/%b/0",
                          k, cur_swclk, cur_oe, cur_o, cur_rsp_valid, cur_ready, exp_oe[k],
                          exp_o[k]);
        mism++;
      end
      cap_o.push_back(cur_o);
      repeat (cd()) @(posedge sck);
      #1;
      req_valid = 1'b0;
      if (cur_swclk !== 1'b1 || cur_oe !== exp_oe[k] || (exp_oe[k] && cur_o !== exp_o[k]) ||
          cur_rsp_valid !== 1'b0) begin
        if (mism == 0)
          msg = $sformatf("bit %0d hi: clk=%b oe=%b o=%b vld=%b want 1/%b/%b/0",
                          k, cur_swclk, cur_oe, cur_o, cur_rsp_valid, exp_oe[k], exp_o[k]);
        mism++;
      end
      repeat (cd()) @(posedge sck);
      #1;
    end
    n_checks++;
    if (mism != 0) $display("FAIL %s wire: %0d bad, first %s", name, mism, msg);
    else n_pass++;
    n_checks++;
    if (cur_rsp_valid !== 1'b1) $display("FAIL %s rsp_valid: got %b want 1", name, cur_rsp_valid);
    else n_pass++;
    n_checks++;
    if ({cur_ack, cur_rdata, cur_perr, cur_ret} !== {e_ack, e_rdata, e_perr, e_ret})
      $display("FAIL %s rsp: got ack=%b rd=%h pe=%b rt=%0d want ack=%b rd=%h pe=%b rt=%0d",
               name, cur_ack, cur_rdata, cur_perr, cur_ret, e_ack, e_rdata, e_perr, e_ret);
    else n_pass++;
    @(posedge sck);
    #1;
    n_checks++;
    if ({cur_rsp_valid, cur_ready, cur_ack, cur_rdata, cur_perr, cur_ret} !==
        {1'b0, 1'b1, e_ack, e_rdata, e_perr, e_ret})
      $display("FAIL %s after: got vld=%b rdy=%b ack=%b rd=%h want vld=0 rdy=1 ack=%b rd=%h",
               name, cur_rsp_valid, cur_ready, cur_ack, cur_rdata, e_ack, e_rdata);
    else n_pass++;
    mism = 0;
    for (int i = 0; i < int'(4 * cd()); i++) begin
      @(posedge sck);
      #1;
      if (cur_swclk !== 1'b0 || cur_ready !== 1'b1 || cur_rsp_valid !== 1'b0) mism++;
    end
    n_checks++;
    if (mism != 0) $display("FAIL %s idle: got %0d busy cycles want 0", name, mism);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge sck);
    #1;
    n_checks++;
    if ({a_ready, a_oe, a_o, a_swclk, a_rsp_valid, a_ack, a_rdata, a_perr, a_ret,
         b_ready, b_oe, b_o, b_swclk, b_rsp_valid, b_ack, b_rdata, b_perr, b_ret} !== 76'h0)
      $display("FAIL reset_vals: got a rdy=%b oe=%b clk=%b ack=%b, b rdy=%b oe=%b clk=%b want 0",
               a_ready, a_oe, a_swclk, a_ack, b_ready, b_oe, b_swclk);
    else n_pass++;
    rst = 1'b0;
    @(posedge sck);
    #1;
    n_checks++;
    if ({a_ready, a_oe, a_o, b_ready, b_oe, b_o} !== 6'b110110)
      $display("FAIL reset_release: got %b want 110110", {a_ready, a_oe, a_o, b_ready, b_oe, b_o});
    else n_pass++;
  endtask

  task automatic test_write();
    logic [7:0] hdr;
    run_xfer("write_deadbeef", 1'b0, 1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 32'h0, 1'b0, 0, 3'b001,
             -1, -1);
    hdr = 8'h00;
    for (int i = 0; i < 8 && i < cap_o.size(); i++) hdr[i] = cap_o[i];
    n_checks++;
    if (hdr !== 8'b1010_1001 || cap_o.size() < 8)
      $display("FAIL write_header: got %b want 10101001", hdr);
    else n_pass++;
  endtask

  task automatic test_read();
    run_xfer("read_ok", 1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'h12345678, 1'b0, 0, 3'b001, -1, -1);
    run_xfer("read_perr", 1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'h12345678, 1'b1, 0, 3'b001, -1, -1);
  endtask

  task automatic test_wait();
    run_xfer("wait2_ok", 1'b0, 1'b0, 1'b1, 2'b11, 32'h0, $urandom, 1'b0, 2, 3'b001, -1, -1);
    run_xfer("wait_exhaust", 1'b0, 1'b1, 1'b0, 2'b00, $urandom, 32'h0, 1'b0, int'(mr()) + 1,
             3'b001, -1, -1);
  endtask

  task automatic test_fault();
    run_xfer("fault", 1'b0, 1'b0, 1'b1, 2'b01, 32'h0, $urandom, 1'b0, 0, 3'b100, -1, -1);
    run_xfer("noresp", 1'b0, 1'b1, 1'b0, 2'b10, $urandom, 32'h0, 1'b0, 0, 3'b111, -1, -1);
  endtask

  task automatic test_lrst();
    run_xfer("lrst", 1'b1, 1'b1, 1'b1, 2'b11, $urandom, 32'h0, 1'b0, 0, 3'b001, 20, -1);
  endtask

  task automatic test_abort();
    run_xfer("abort_wdata10", 1'b0, 1'b0, 1'b0, 2'b10, $urandom, 32'h0, 1'b0, 0, 3'b001, -1,
             8 + 2 * int'(tw()) + 3 + 10);
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      int         kind;
      int         nw;
      logic [2:0] fa;
      bit         lr;
      kind = $urandom_range(0, 5);
      nw   = 0;
      fa   = 3'b001;
      lr   = 1'b0;
      case (kind)
        0: lr = 1'b1;
        3: nw = $urandom_range(1, mr());
        4: begin
          fa = 3'($urandom_range(0, 7));
          if (fa == 3'b001) fa = 3'b100;
        end
        5: nw = int'(mr()) + 1;
        default: ;
      endcase
      run_xfer($sformatf("rand_%0d_%0d", sel, t), lr, rb(), rb(), 2'($urandom_range(0, 3)),
               $urandom, $urandom, rb(), nw, fa, -1, -1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    sel = 1'b0;
    test_write();
    test_read();
    test_wait();
    test_fault();
    test_lrst();
    test_abort();
    test_random(12);
    sel = 1'b1;
    test_lrst();
    test_abort();
    test_wait();
    test_read();
    test_random(12);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
